regfile_mp: RTL and testbench



---
 rtl/regfile_mp_if.sv | 37 +++
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: two write ports, pending-set port,
// packed read ports with busy flags, and the ready indication.
interface regfile_mp_if #(
   parameter int N  = 32,
   parameter int L  = 32,
   parameter int NR = 2,
   parameter int AW = $clog2(L)
);
   logic              we1;
   logic [AW-1:0]     wa1;
   logic [N-1:0]      wd1;
   logic              we2;
   logic [AW-1:0]     wa2;
   logic [N-1:0]      wd2;
   logic              setp;
   logic [AW-1:0]     pa;
   logic [NR*AW-1:0]  ra;
   logic [NR*N-1:0]   rd;
   logic [NR-1:0]     rbusy;
   logic              ready;

   modport master (
      output we1, wa1, wd1,
      output we2, wa2, wd2,
      output setp, pa,
      output ra,
      input  rd, rbusy, ready
   );

   modport slave (
      input  we1, wa1, wd1,
      input  we2, wa2, wd2,
      input  setp, pa,
      input  ra,
      output rd, rbusy, ready
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NR bypassed read ports,
// per-entry pending scoreboard, and a post-reset sequencer that zeroes every entry.
module regfile_mp #(
   parameter int N  = 32,
   parameter int L  = 32,
   parameter int NR = 2
) (
   input  logic        clk,
   input  logic        reset,
   regfile_mp_if.slave bus
);
   localparam int AW = $clog2(L);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW-1:0]   r_cnt;
   logic [L-1:0]    r_pend;
   logic [L-1:0]    w_pend_nxt;
   logic [N-1:0]    r_rf [L];

   logic            w_run;
   logic            w_clr_last;
   logic            w_eff1;
   logic            w_eff2;
   logic            w_store1;
   logic            w_setp_eff;

   // state register and clear counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_CLEAR: if (w_clr_last) w_state_nxt = S_RUN;
         S_RUN:   w_state_nxt = S_RUN;
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      w_run      = (r_state == S_RUN);
      w_clr_last = (r_state == S_CLEAR) && (r_cnt == AW'(L - 1));
      bus.ready  = w_run;
   end

   // Write qualification; port 2 wins a same-address collision.
   assign w_eff1     = w_run && bus.we1 && (bus.wa1 != '0);
   assign w_eff2     = w_run && bus.we2 && (bus.wa2 != '0);
   assign w_store1   = w_eff1 && !(w_eff2 && (bus.wa1 == bus.wa2));
   assign w_setp_eff = w_run && bus.setp && (bus.pa != '0);

   // Storage is never reset; the clear sequencer zeroes it instead.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (!w_run) begin
            r_rf[r_cnt] <= '0;
         end else begin
            if (w_store1) r_rf[bus.wa1] <= bus.wd1;
            if (w_eff2)   r_rf[bus.wa2] <= bus.wd2;
         end
      end
   end

   // Set is applied after the clears so a new producer supersedes the old one.
   always_comb begin
      w_pend_nxt = r_pend;
      if (w_eff1)     w_pend_nxt[bus.wa1] = 1'b0;
      if (w_eff2)     w_pend_nxt[bus.wa2] = 1'b0;
      if (w_setp_eff) w_pend_nxt[bus.pa]  = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end

   // Read ports: zero during CLEAR and for entry 0, then port-2 / port-1 bypass, then array.
   for (genvar gi = 0; gi < NR; gi++) begin : g_rd
      logic [AW-1:0] w_ra;
      logic          w_hit1;
      logic          w_hit2;
      logic [N-1:0]  w_rd;

      assign w_ra   = bus.ra[gi*AW +: AW];
      assign w_hit2 = w_eff2 && (bus.wa2 == w_ra);
      assign w_hit1 = w_eff1 && (bus.wa1 == w_ra);

      assign w_rd = (!w_run || (w_ra == '0)) ? '0      :
                    w_hit2                   ? bus.wd2 :
                    w_hit1                   ? bus.wd1 :
                                               r_rf[w_ra];

      assign bus.rd[gi*N +: N] = w_rd;
      assign bus.rbusy[gi]     = w_run && r_pend[w_ra] && !(w_hit1 || w_hit2);
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sequencing, writes, collisions, bypass and scoreboard.
module tb_regfile_mp;
   localparam int N  = 32;
   localparam int L  = 32;
   localparam int NR = 3;
   localparam int AW = 5;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   regfile_mp_if #(.N(N), .L(L), .NR(NR)) bus ();

   regfile_mp #(.N(N), .L(L), .NR(NR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic          we1;
      logic [AW-1:0] wa1;
      logic [N-1:0]  wd1;
      logic          we2;
      logic [AW-1:0] wa2;
      logic [N-1:0]  wd2;
      logic          setp;
      logic [AW-1:0] pa;
      logic [AW-1:0] ra0, ra1, ra2;
      logic [N-1:0]  e0, e1, e2;
      logic [NR-1:0] eb;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(
      input logic we1, input logic [AW-1:0] wa1, input logic [N-1:0] wd1,
      input logic we2, input logic [AW-1:0] wa2, input logic [N-1:0] wd2,
      input logic setp, input logic [AW-1:0] pa,
      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
      input logic [N-1:0] e0, input logic [N-1:0] e1, input logic [N-1:0] e2,
      input logic [NR-1:0] eb);
      vec_t v;
      v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
      v.we2 = we2; v.wa2 = wa2; v.wd2 = wd2;
      v.setp = setp; v.pa = pa;
      v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
      v.e0 = e0; v.e1 = e1; v.e2 = e2; v.eb = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.we1  = v.we1;  bus.wa1 = v.wa1; bus.wd1 = v.wd1;
      bus.we2  = v.we2;  bus.wa2 = v.wa2; bus.wd2 = v.wd2;
      bus.setp = v.setp; bus.pa  = v.pa;
      bus.ra   = {v.ra2, v.ra1, v.ra0};
   endtask

   task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1, 0, 0, 0, 0, 0));
   endtask

   // One cycle per call: drive at negedge, sample mid-low phase, then cross one posedge.
   task automatic apply_vec(input vec_t v, input int idx);
      string s;
      drive(v);
      #2;
      s = $sformatf("vec%0d", idx);
      chk({s, ".rd0"},   bus.rd[0*N +: N], v.e0);
      chk({s, ".rd1"},   bus.rd[1*N +: N], v.e1);
      chk({s, ".rd2"},   bus.rd[2*N +: N], v.e2);
      chk({s, ".rbusy"}, N'(bus.rbusy),    N'(v.eb));
      chk({s, ".ready"}, N'(bus.ready),    N'(1));
      @(negedge clk);
   endtask

   initial begin
      int n;
      n_chk = 0;
      n_err = 0;
      reset = 1'b1;
      idle(0, 0);

      // Initial reset and full clear sequence
      repeat (3) @(negedge clk);
      #2;
      chk("reset.ready", N'(bus.ready), 0);
      chk("reset.rbusy", N'(bus.rbusy), 0);
      reset = 1'b0;
      idle(5, 0);
      for (int k = 0; k < L; k++) begin
         #2;
         chk($sformatf("clr1.ready%0d", k), N'(bus.ready), 0);
         chk($sformatf("clr1.rd%0d", k), bus.rd[0 +: N], 0);
         @(negedge clk);
      end
      #2;
      chk("clr1.ready_at_L", N'(bus.ready), 1);
      @(negedge clk);

      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   3, 0, 5,   0, 0, 0, 3'b000));
      tv.push_back(mk(1, 3, 32'hDEADBEEF, 0, 0, 0,          0, 0,   3, 0, 0,   32'hDEADBEEF, 0, 0, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   3, 0, 0,   32'hDEADBEEF, 0, 0, 3'b000));
      tv.push_back(mk(1, 0, 32'h1234,     0, 0, 0,          0, 0,   0, 3, 0,   0, 32'hDEADBEEF, 0, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   0, 0, 0,   0, 0, 0, 3'b000));
      tv.push_back(mk(1, 7, 32'h11,       1, 7, 32'h22,     0, 0,   7, 7, 0,   32'h22, 32'h22, 0, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   7, 0, 0,   32'h22, 0, 0, 3'b000));
      tv.push_back(mk(1, 4, 32'h44,       1, 9, 32'h99,     0, 0,   4, 9, 3,   32'h44, 32'h99, 32'hDEADBEEF, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   4, 9, 7,   32'h44, 32'h99, 32'h22, 3'b000));
      tv.push_back(mk(1, 6, 32'h0BAD,     0, 0, 0,          0, 0,   6, 0, 0,   32'h0BAD, 0, 0, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   6, 6, 6,   32'h0BAD, 32'h0BAD, 32'h0BAD, 3'b000));
      tv.push_back(mk(0, 0, 0,            1, 6, 32'hCAFE,   0, 0,   6, 6, 6,   32'hCAFE, 32'hCAFE, 32'hCAFE, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   6, 6, 6,   32'hCAFE, 32'hCAFE, 32'hCAFE, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          1, 12,  12, 0, 0,  0, 0, 0, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   12, 12, 0, 0, 0, 0, 3'b011));
      tv.push_back(mk(1, 12, 32'h1212,    0, 0, 0,          0, 0,   12, 12, 0, 32'h1212, 32'h1212, 0, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   12, 0, 0,  32'h1212, 0, 0, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          1, 12,  12, 0, 0,  32'h1212, 0, 0, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   12, 0, 0,  32'h1212, 0, 0, 3'b001));
      tv.push_back(mk(0, 0, 0,            1, 12, 32'h2,     1, 12,  12, 0, 0,  32'h2, 0, 0, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   12, 0, 0,  32'h2, 0, 0, 3'b001));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          1, 0,   0, 0, 0,   0, 0, 0, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   0, 12, 0,  0, 32'h2, 0, 3'b010));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          1, 20,  12, 20, 0, 32'h2, 0, 0, 3'b001));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   12, 20, 0, 32'h2, 0, 0, 3'b011));
      tv.push_back(mk(1, 20, 32'h2020,    0, 0, 0,          0, 0,   12, 20, 0, 32'h2, 32'h2020, 0, 3'b001));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   12, 20, 0, 32'h2, 32'h2020, 0, 3'b001));
      tv.push_back(mk(0, 3, 32'hFFFFFFFF, 0, 3, 32'hEEEE,   0, 0,   3, 0, 0,   32'hDEADBEEF, 0, 0, 3'b000));
      tv.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,   3, 0, 0,   32'hDEADBEEF, 0, 0, 3'b000));

      for (int i = 0; i < tv.size(); i++) apply_vec(tv[i], i);

      // Preload r5 and mark it pending before a second reset
      drive(mk(1, 5, 32'h5555, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      idle(5, 0);
      #2;
      chk("pre.rd5", bus.rd[0 +: N], 32'h5555);
      chk("pre.busy5", N'(bus.rbusy), 1);

      // Second clear: writes and setp during CLEAR must be ignored
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < L; k++) begin
         if (k == 3) drive(mk(1, 2, 32'h55, 1, 5, 32'h77, 1, 2, 5, 2, 0, 0, 0, 0, 0));
         else        idle(5, 2);
         #2;
         chk($sformatf("clr2.ready%0d", k), N'(bus.ready), 0);
         chk($sformatf("clr2.rd5_%0d", k), bus.rd[0 +: N], 0);
         chk($sformatf("clr2.rd2_%0d", k), bus.rd[N +: N], 0);
         chk($sformatf("clr2.rbusy%0d", k), N'(bus.rbusy), 0);
         @(negedge clk);
      end
      idle(5, 2);
      #2;
      chk("clr2.ready_at_L", N'(bus.ready), 1);
      chk("clr2.rd5", bus.rd[0 +: N], 0);
      chk("clr2.rd2", bus.rd[N +: N], 0);
      chk("clr2.rbusy", N'(bus.rbusy), 0);

      // Reset pulse in the middle of a clear restarts the full sequence
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      #2;
      while (!bus.ready && n < 100) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk("midrst.edges_to_ready", N'(n), N'(L));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
